// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined filter-datapath ALU with internal accumulator,
// valid/ready handshake on both sides and a sticky wrap-around overflow flag.
// Optional build macro ALU_PIPE_ROUND_EN: SATA rounds half-up before shifting
// (default: floor shift).
// myfilter_pkg is kept in this file so the block compiles stand-alone.

package myfilter_pkg;

    parameter int DATABITS = 16;
    parameter int ACCBITS  = 40;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_M1   = 5'd1,
        ALU_M2   = 5'd2,
        ALU_MU   = 5'd3,
        ALU_ACN  = 5'd4,
        ALU_M1N  = 5'd5,
        ALU_M2N  = 5'd6,
        ALU_MUN  = 5'd7,
        ALU_ADAC = 5'd8,
        ALU_ADM1 = 5'd9,
        ALU_ADM2 = 5'd10,
        ALU_ADMU = 5'd11,
        ALU_SUAC = 5'd12,
        ALU_SUM1 = 5'd13,
        ALU_SUM2 = 5'd14,
        ALU_SUMU = 5'd15,
        ALU_SATA = 5'd16
    } alu_cmd_t;

endpackage

module alu_pipe
    import myfilter_pkg::*;
#(
    parameter int unsigned DW    = DATABITS,
    parameter int unsigned AW    = ACCBITS,
    parameter int unsigned SHIFT = DW - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] m1_in,
    input  logic [DW-1:0] m2_in,
    input  alu_cmd_t      cmd_in,
    input  logic          acc_sel,
    input  logic          clr_in,
    input  logic [AW-1:0] acc_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] d_out,
    output logic          ovf_out,
    input  logic          ovf_clr
);

    // SATA clamp bounds, held in the AW+1-bit result domain
    localparam logic signed [AW:0] SAT_MAX = {{(AW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = {{(AW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};
`ifdef ALU_PIPE_ROUND_EN
    localparam logic signed [AW:0] SAT_RND = (AW + 1)'(1) << (SHIFT - 1);
`endif

    logic                   adv;
    logic signed [2*DW-1:0] prod;

    // Stage 1 registers
    logic                   s1_valid_q;
    logic signed [DW-1:0]   s1_m1_q;
    logic signed [DW-1:0]   s1_m2_q;
    alu_cmd_t               s1_cmd_q;
    logic                   s1_acc_sel_q;
    logic                   s1_clr_q;
    logic signed [AW-1:0]   s1_acc_q;
    logic signed [AW-1:0]   s1_prod_q;

    // Stage 2 / output registers
    logic                   out_valid_q;
    logic [AW-1:0]          d_out_q;
    logic signed [AW-1:0]   acc_reg_q;
    logic                   ovf_q;

    // Stage 2 combinational datapath
    logic signed [AW-1:0]   acc_op;
    logic signed [AW:0]     a_x;
    logic signed [AW:0]     m1_x;
    logic signed [AW:0]     m2_x;
    logic signed [AW:0]     p_x;
    logic signed [AW:0]     sat_in;
    logic signed [AW:0]     sat_sh;
    logic signed [AW:0]     sat_res;
    logic signed [AW:0]     res;
    logic                   res_ovf;
    logic                   new_ovf;

    // A single stall signal freezes the whole pipe; in_ready drops whenever the
    // output is held, even with stage 1 empty.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign prod = (2 * DW)'($signed(m1_in)) * (2 * DW)'($signed(m2_in));

    // Stage 1: capture command, operands and the full-precision product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_m1_q      <= '0;
            s1_m2_q      <= '0;
            s1_cmd_q     <= ALU_NOP;
            s1_acc_sel_q <= 1'b0;
            s1_clr_q     <= 1'b0;
            s1_acc_q     <= '0;
            s1_prod_q    <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_m1_q      <= $signed(m1_in);
                s1_m2_q      <= $signed(m2_in);
                s1_cmd_q     <= cmd_in;
                s1_acc_sel_q <= acc_sel;
                s1_clr_q     <= clr_in;
                s1_acc_q     <= $signed(acc_in);
                s1_prod_q    <= AW'(prod);
            end
        end
    end

    // Stage 2: select accumulator operand and evaluate the command in AW+1 bits
    always_comb begin
        acc_op  = s1_clr_q ? '0 : (s1_acc_sel_q ? acc_reg_q : s1_acc_q);
        a_x     = (AW + 1)'(acc_op);
        m1_x    = (AW + 1)'(s1_m1_q);
        m2_x    = (AW + 1)'(s1_m2_q);
        p_x     = (AW + 1)'(s1_prod_q);
`ifdef ALU_PIPE_ROUND_EN
        sat_in  = a_x + SAT_RND;
`else
        sat_in  = a_x;
`endif
        sat_sh  = sat_in >>> SHIFT;
        if (sat_sh > SAT_MAX) begin
            sat_res = SAT_MAX;
        end else if (sat_sh < SAT_MIN) begin
            sat_res = SAT_MIN;
        end else begin
            sat_res = sat_sh;
        end

        res = a_x;
        case (s1_cmd_q)
            ALU_NOP:  res = a_x;
            ALU_M1:   res = m1_x;
            ALU_M2:   res = m2_x;
            ALU_MU:   res = p_x;
            ALU_ACN:  res = -a_x;
            ALU_M1N:  res = -m1_x;
            ALU_M2N:  res = -m2_x;
            ALU_MUN:  res = -p_x;
            ALU_ADAC: res = a_x + a_x;
            ALU_ADM1: res = a_x + m1_x;
            ALU_ADM2: res = a_x + m2_x;
            ALU_ADMU: res = a_x + p_x;
            ALU_SUAC: res = a_x - a_x;
            ALU_SUM1: res = a_x - m1_x;
            ALU_SUM2: res = a_x - m2_x;
            ALU_SUMU: res = a_x - p_x;
            ALU_SATA: res = sat_res;
            default:  res = a_x;
        endcase

        // Result fits in AW bits only if the top two bits agree; SATA always fits
        res_ovf = res[AW] != res[AW-1];
        new_ovf = adv && s1_valid_q && res_ovf;
    end

    // Output stage: publish result and update the accumulator on every valid op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            d_out_q     <= '0;
            acc_reg_q   <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                d_out_q   <= res[AW-1:0];
                acc_reg_q <= res[AW-1:0];
            end
        end
    end

    // Sticky overflow: a new overflow takes priority over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= new_ovf || (ovf_q && !ovf_clr);
        end
    end

    assign out_valid = out_valid_q;
    assign d_out     = d_out_q;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: stimulus pushes expected results, a monitor
// pops them whenever an output transfer happens.
module tb_alu_pipe;
    import myfilter_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 40;
    localparam int SHIFT = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] m1_in = '0;
    logic [DW-1:0] m2_in = '0;
    alu_cmd_t      cmd_in = ALU_NOP;
    logic          acc_sel = 1'b0;
    logic          clr_in = 1'b0;
    logic [AW-1:0] acc_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] d_out;
    logic          ovf_out;
    logic          ovf_clr = 1'b0;

    alu_pipe #(.DW(DW), .AW(AW), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m1_in     (m1_in),
        .m2_in     (m2_in),
        .cmd_in    (cmd_in),
        .acc_sel   (acc_sel),
        .clr_in    (clr_in),
        .acc_in    (acc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .ovf_out   (ovf_out),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] d;
        bit            chk_ovf;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     n_pop = 0;
    longint acc_model = 0;
    bit     bp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        longint r;
        r = longint'(v);
        r = (r <<< (64 - w)) >>> (64 - w);
        return r;
    endfunction

    // Reference: arithmetic on 64-bit integers, then fit to AW bits
    function automatic longint model_op(input alu_cmd_t c, input longint m1, input longint m2,
                                        input longint a);
        longint p, t, lim;
        p   = m1 * m2;
        lim = longint'(1) <<< (DW - 1);
        case (c)
            ALU_NOP:  return a;
            ALU_M1:   return m1;
            ALU_M2:   return m2;
            ALU_MU:   return p;
            ALU_ACN:  return -a;
            ALU_M1N:  return -m1;
            ALU_M2N:  return -m2;
            ALU_MUN:  return -p;
            ALU_ADAC: return a + a;
            ALU_ADM1: return a + m1;
            ALU_ADM2: return a + m2;
            ALU_ADMU: return a + p;
            ALU_SUAC: return 0;
            ALU_SUM1: return a - m1;
            ALU_SUM2: return a - m2;
            ALU_SUMU: return a - p;
            ALU_SATA: begin
`ifdef ALU_PIPE_ROUND_EN
                t = (a + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`else
                t = a >>> SHIFT;
`endif
                if (t > lim - 1) t = lim - 1;
                if (t < -lim) t = -lim;
                return t;
            end
            default:  return a;
        endcase
    endfunction

    // Drive one command, wait for acceptance, push its expected result.
    // With dir=1 the pushed value is the given constant instead of the model's.
    task automatic issue(input alu_cmd_t c, input logic [15:0] a1, input logic [15:0] a2,
                         input bit sel, input bit cl, input logic [39:0] ain,
                         input bit dir, input logic [39:0] dexp, input bit dovf);
        int          t;
        longint      a, r, big;
        logic [63:0] rr;
        exp_t        e;
        cmd_in   = c;
        m1_in    = a1;
        m2_in    = a2;
        acc_sel  = sel;
        clr_in   = cl;
        acc_in   = ain;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 at %0t", $time);
            in_valid = 1'b0;
            return;
        end
        a   = cl ? 0 : (sel ? acc_model : sx({24'h0, ain}, AW));
        r   = model_op(c, sx({48'h0, a1}, DW), sx({48'h0, a2}, DW), a);
        big = longint'(1) <<< (AW - 1);
        rr  = r;
        acc_model = sx(rr, AW);
        if (dir) begin
            e.d       = dexp;
            e.chk_ovf = dovf;
        end else begin
            e.d       = rr[AW-1:0];
            e.chk_ovf = (r > big - 1) || (r < -big);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_rand();
        logic [39:0] ain;
        ain = {$urandom_range(0, 255), $urandom};
        if ($urandom_range(0, 3) == 0) ain = sx({24'h0, ain}, AW) > 0 ? {20'h0, ain[19:0]} : ain;
        issue(alu_cmd_t'(5'($urandom_range(0, 31))), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, ain, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending got %0d expected 0", sb_q.size());
        end
    endtask

    // Fixed latency: visible after the second edge following acceptance
    task automatic latency_mu();
        issue(ALU_MU, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 40'h0, 1'b1, 40'h003FFF0001, 1'b0);
        chk("lat_n1_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_n2_out_valid", 64'(out_valid), 64'd1);
        chk("lat_n2_d_out", 64'(d_out), 64'h003FFF0001);
        chk("lat_n2_ovf", 64'(ovf_out), 64'd0);
    endtask

    // Monitor: compare on each output transfer; check freeze while stalled
    logic          stalled_prev = 1'b0;
    logic [AW-1:0] held_d;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                chk("stall_d_out_stable", 64'(d_out), 64'(held_d));
                chk("stall_out_valid_held", 64'(out_valid), 64'd1);
            end
            stalled_prev = out_valid && !out_ready;
            held_d       = d_out;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h expected none", d_out);
                end else begin
                    e = sb_q.pop_front();
                    n_pop++;
                    chk("d_out", 64'(d_out), 64'(e.d));
                    if (e.chk_ovf) chk("ovf_out", 64'(ovf_out), 64'd1);
                end
            end
        end
    end

    // Random output backpressure
    always @(posedge clk) begin
        #1;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pop0;
        int t;
        // Reset values
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_d_out", 64'(d_out), 64'd0);
        chk("rst_ovf", 64'(ovf_out), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        latency_mu();
        wait_drain();

        // Back-to-back accumulation through acc_reg
        issue(ALU_ADMU, 16'd3, 16'd4, 1'b1, 1'b1, 40'h0, 1'b1, 40'd12, 1'b0);
        issue(ALU_ADMU, 16'd5, 16'd6, 1'b1, 1'b0, 40'h0, 1'b1, 40'd42, 1'b0);
        issue(ALU_ADMU, 16'hFFF9, 16'd2, 1'b1, 1'b0, 40'h0, 1'b1, 40'd28, 1'b0);
        wait_drain();

        // Saturating shift
        issue(ALU_SATA, 16'h0, 16'h0, 1'b0, 1'b0, 40'h0040000000, 1'b1, 40'h0000007FFF, 1'b0);
        issue(ALU_SATA, 16'h0, 16'h0, 1'b0, 1'b0, 40'hFF00000000, 1'b1, 40'hFFFFFF8000, 1'b0);
`ifdef ALU_PIPE_ROUND_EN
        issue(ALU_SATA, 16'h0, 16'h0, 1'b0, 1'b0, 40'h0000004000, 1'b1, 40'd1, 1'b0);
`else
        issue(ALU_SATA, 16'h0, 16'h0, 1'b0, 1'b0, 40'h0000004000, 1'b1, 40'd0, 1'b0);
`endif
        wait_drain();
        chk("sata_no_ovf", 64'(ovf_out), 64'd0);

        // Overflow: sticky, cleared by ovf_clr, new overflow beats clear
        issue(ALU_ACN, 16'h0, 16'h0, 1'b0, 1'b0, 40'h8000000000, 1'b1, 40'h8000000000, 1'b1);
        repeat (10) issue(ALU_NOP, 16'h0, 16'h0, 1'b0, 1'b0, 40'h0, 1'b1, 40'h0, 1'b0);
        wait_drain();
        chk("ovf_sticky", 64'(ovf_out), 64'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", 64'(ovf_out), 64'd0);
        issue(ALU_ACN, 16'h0, 16'h0, 1'b0, 1'b0, 40'h8000000000, 1'b1, 40'h8000000000, 1'b1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_wins_over_clr", 64'(ovf_out), 64'd1);
        wait_drain();

        // Reset mid-stream: in-flight ops discarded
        repeat (4) issue_rand();
        issue(ALU_M1, 16'h1234, 16'h0, 1'b0, 1'b0, 40'h0, 1'b1, 40'h1234, 1'b0);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        acc_model = 0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_d_out", 64'(d_out), 64'd0);
        chk("midrst_ovf", 64'(ovf_out), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        latency_mu();
        wait_drain();

        // Random commands with random backpressure
        bp_en = 1'b1;
        repeat (300) issue_rand();
        bp_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();

        // Six-op stream with a 3-cycle stall after the first result
        pop0 = n_pop;
        fork
            begin
                repeat (6) issue(alu_cmd_t'(5'($urandom_range(8, 15))), 16'($urandom),
                                 16'($urandom), 1'b1, 1'b0, 40'h0, 1'b0, '0, 1'b0);
            end
            begin
                t = 0;
                while (!out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("stream_count", 64'(n_pop - pop0), 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the filter datapath ALU. Executes the `alu_cmd_t` command set from `myfilter_pkg` on signed operands, with an internal accumulator register, a valid/ready handshake on input and output, wrap-around overflow detection and a configurable saturating shift. Sits between the filter sequencer (command/operand source) and the coefficient/sample path, replacing the combinational ALU plus external accumulator register.

## Interface
- `DW`, default `DATABITS`: operand width (signed), ≥ 2.
- `AW`, default `ACCBITS`: accumulator/result width (signed), ≥ 2·DW.
- `SHIFT`, default `DW-1`: arithmetic right-shift amount for `ALU_SATA`, 1 ≤ SHIFT < AW.

- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: command/operands valid.
- `in_ready` out 1: block accepts this cycle.
- `m1_in` in DW: operand 1, two's complement.
- `m2_in` in DW: operand 2, two's complement.
- `cmd_in` in `alu_cmd_t`: operation.
- `acc_sel` in 1: 1 = accumulator operand is internal `acc_reg`, 0 = `acc_in`.
- `clr_in` in 1: force accumulator operand to 0 for this command.
- `acc_in` in AW: external accumulator operand.
- `out_valid` out 1: `d_out` valid.
- `out_ready` in 1: consumer takes `d_out`.
- `d_out` out AW: result, two's complement.
- `ovf_out` out 1: sticky overflow flag.
- `ovf_clr` in 1: synchronous clear of `ovf_out`.

## Operation
- Accept on `in_valid && in_ready`. Global stall: `adv = !out_valid || out_ready`; `in_ready = adv`; both stages update only when `adv`.
- Stage 1 registers m1, m2, cmd, acc_sel, clr, acc_in, and product `m1*m2` (2·DW, sign-extended to AW), plus valid bit.
- Stage 2 (combinational from stage 1 and `acc_reg`) computes result in AW+1 bits: acc operand `A` = 0 if clr, else `acc_reg` if acc_sel, else acc_in.
- Commands: NOP→A; M1/M2/MU→m1/m2/prod; ACN/M1N/M2N/MUN→negated; ADAC/ADM1/ADM2/ADMU→A+A/m1/m2/prod; SUAC/SUM1/SUM2/SUMU→A−A/m1/m2/prod; SATA→`A >>> SHIFT` clamped to [−2^(DW−1), 2^(DW−1)−1], sign-extended to AW. Undefined codes behave as NOP.
- Overflow: if the AW+1-bit result does not fit in AW, `d_out` takes the low AW bits (wrap) and `ovf_out` sets. SATA never overflows.
- On a valid stage-2 advance: `d_out` ← result, `out_valid` ← 1, and `acc_reg` ← result (every valid op, independent of acc_sel). On advance with empty stage 1: `out_valid` ← 0, `d_out` and `acc_reg` hold.
- `ovf_clr` clears `ovf_out`; same-cycle new overflow wins (flag stays 1).

## Timing
- Reset values: `out_valid`=0, `d_out`=0, `ovf_out`=0, `acc_reg`=0, stage-1 valid=0; `in_ready`=1 (derived).
- Latency: command accepted at edge N → `d_out`/`out_valid` at edge N+2. Throughput 1 op/cycle while `out_ready`=1.
- Back-to-back ops using `acc_reg` need no bubble: op k+1 in stage 2 sees `acc_reg` written by op k.
- Backpressure: `out_valid && !out_ready` freezes both stages, `d_out`, `acc_reg`; `in_ready`=0 even if stage 1 is empty.
- Reset mid-operation discards all in-flight ops; no output is produced for them.

## Configuration
- `ALU_PIPE_ROUND_EN` defined: SATA adds 2^(SHIFT−1) to A (in AW+1 bits) before the shift, i.e. round-half-up, then clamps.
- Not defined: SATA truncates (floor shift) then clamps. All other commands identical.

## Test plan
(DW=16, AW=40, SHIFT=15.)
- Reset asserted mid-stream → `out_valid`=0, `d_out`=0, `ovf_out`=0, `in_ready`=1; first op after release appears 2 cycles after acceptance.
- MU, m1=0x7FFF, m2=0x7FFF, acc_sel=0 → `d_out`=0x003FFF0001 at N+2, `ovf_out`=0.
- Consecutive cycles: ADMU clr=1 acc_sel=1 (3,4), then ADMU acc_sel=1 (5,6), then ADMU acc_sel=1 (−7,2) → `d_out` 12, 42, 28 on three consecutive cycles.
- SATA acc_in=0x0040000000 → 0x0000007FFF; acc_in=0xFF00000000 → 0xFFFFFF8000; acc_in=0x0000004000 → 0 without macro, 1 with `ALU_PIPE_ROUND_EN`.
- ACN acc_in=0x8000000000 → `d_out`=0x8000000000, `ovf_out`=1, held through 10 NOPs, cleared by `ovf_clr`; overflow coincident with `ovf_clr` → stays 1.
- Stream 6 ops with `out_ready` low 3 cycles after first `out_valid` → `in_ready`=0, `d_out` stable while stalled, all 6 results delivered in order, none duplicated.
